// File: rtl/led_seq_pkg.sv
// Shared types and defaults for the WS2812B frame sequencer.
// Holds the FSM state encoding, colour width and per-byte brightness scaling.
package led_seq_pkg;

  localparam int PIX_W            = 24;
  localparam int DEF_NUM_LEDS     = 140;
  localparam int DEF_ADDR_W       = 8;
  localparam int DEF_REFRESH_LOG2 = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    WAIT_READY,
    WAIT_ACCEPT
  } seq_state_e;

  // Each colour byte is dimmed independently so the hue is roughly preserved.
  function automatic logic [PIX_W-1:0] scale_pix(input logic [PIX_W-1:0] pix,
                                                 input logic [2:0]       shift);
    logic [7:0] r, g, b;
    r = pix[23:16] >> shift;
    g = pix[15:8]  >> shift;
    b = pix[7:0]   >> shift;
    return {r, g, b};
  endfunction

endpackage

// File: rtl/led_frame_sequencer_if.sv
// Valid/ready/latch handshake between the frame sequencer and the ws2812b serializer.
// The master modport is the sequencer side; the slave modport is the serializer side.
interface led_frame_sequencer_if import led_seq_pkg::*; ();

  logic [PIX_W-1:0] led_data;
  logic             led_valid;
  logic             led_latch;
  logic             led_ready;

  modport master (output led_data, output led_valid, output led_latch, input led_ready);
  modport slave  (input led_data, input led_valid, input led_latch, output led_ready);

endinterface

// File: rtl/refresh_timer.sv
// Free-running refresh timer: tick is registered high for one cycle each time
// the REFRESH_LOG2-bit counter is all ones.
module refresh_timer import led_seq_pkg::*; #(
  parameter int REFRESH_LOG2 = DEF_REFRESH_LOG2
) (
  input  logic clk20,
  input  logic reset,
  output logic tick
);

  logic [REFRESH_LOG2-1:0] cnt;

  always_ff @(posedge clk20) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= &cnt;
    end
  end

endmodule

// File: rtl/led_frame_sequencer.sv
// Frame-level controller: walks pixels 0..NUM_LEDS-1 into the ws2812b serializer.
// Optional global brightness is built in when LED_SEQ_BRIGHTNESS_EN is defined.
module led_frame_sequencer import led_seq_pkg::*; #(
  parameter int NUM_LEDS     = DEF_NUM_LEDS,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int REFRESH_LOG2 = DEF_REFRESH_LOG2
) (
  input  logic                   clk20,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   force_refresh,
  output logic                   pix_rd,
  output logic [ADDR_W-1:0]      pix_addr,
  input  logic [PIX_W-1:0]       pix_data,
`ifdef LED_SEQ_BRIGHTNESS_EN
  input  logic [2:0]             brightness,
`endif
  led_frame_sequencer_if.master  led,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   frame_skip
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LEDS - 1);

  seq_state_e        state;
  logic [ADDR_W-1:0] idx;
  logic              tick;
  logic              req;
  logic              start;

  refresh_timer #(.REFRESH_LOG2(REFRESH_LOG2)) u_timer (
    .clk20 (clk20),
    .reset (reset),
    .tick  (tick)
  );

  // Requests are never queued: one arriving mid-frame only raises frame_skip.
  assign req   = tick | force_refresh;
  assign start = req & enable;
  assign busy  = (state != IDLE);

`ifdef LED_SEQ_BRIGHTNESS_EN
  logic [2:0] bright_q;

  always_ff @(posedge clk20) begin
    if (reset)                     bright_q <= '0;
    else if (state == IDLE && start) bright_q <= brightness;
  end

  function automatic logic [PIX_W-1:0] pix_out(input logic [PIX_W-1:0] pix);
    return scale_pix(pix, bright_q);
  endfunction
`else
  function automatic logic [PIX_W-1:0] pix_out(input logic [PIX_W-1:0] pix);
    return pix;
  endfunction
`endif

  always_ff @(posedge clk20) begin
    // NOTE: the colour register is cleared on reset too, so the serializer
    // never sees stale data from an aborted frame.
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      pix_rd        <= 1'b0;
      pix_addr      <= '0;
      led.led_data  <= '0;
      led.led_valid <= 1'b0;
      led.led_latch <= 1'b0;
      frame_done    <= 1'b0;
      frame_skip    <= 1'b0;
    end else begin
      // NOTE: strobes default low here with non-blocking assignments; a later
      // assignment in the case below wins, giving clean one-cycle pulses.
      pix_rd     <= 1'b0;
      frame_done <= 1'b0;
      frame_skip <= busy & req;

      case (state)
        IDLE: begin
          idx <= '0;
          if (start) begin
            pix_rd   <= 1'b1;
            pix_addr <= '0;
            state    <= FETCH;
          end
        end

        FETCH: state <= CAPTURE;

        CAPTURE: begin
          led.led_data  <= pix_out(pix_data);
          led.led_latch <= (idx == LAST_IDX);
          state         <= WAIT_READY;
        end

        WAIT_READY: begin
          if (led.led_ready) begin
            led.led_valid <= 1'b1;
            state         <= WAIT_ACCEPT;
          end
        end

        WAIT_ACCEPT: begin
          if (!led.led_ready) begin
            led.led_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              idx        <= '0;
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              idx      <= idx + 1'b1;
              pix_addr <= idx + 1'b1;
              pix_rd   <= 1'b1;
              state    <= FETCH;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/led_frame_sequencer.md
# led_frame_sequencer

Frame-level controller for the WS2812B serializer in the character-matrix display. On each refresh tick it walks pixel indices 0..NUM_LEDS-1 and fetches each 24-bit colour from a pixel source with a fixed one-cycle read latency. It hands each colour to the `ws2812b` serializer over that driver's valid/ready/latch handshake and flags the last pixel so the strip latches. It replaces the ad-hoc refresh loop in the top level and owns refresh pacing, frame skipping and optional global brightness.

## Interface
- `NUM_LEDS`, 140: pixels per frame; must be in the range 1..2^ADDR_W.
- `ADDR_W`, 8: width of the pixel index.
- `REFRESH_LOG2`, 16: the refresh tick fires every 2^REFRESH_LOG2 clocks, about 305 Hz at 20 MHz.

- `clk20` in 1: 20 MHz clock, the only clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: when low, no new frame starts; a frame in flight completes.
- `force_refresh` in 1: one-cycle request to start a frame without waiting for the timer.
- `pix_rd` out 1: pixel read strobe.
- `pix_addr` out ADDR_W: index of the pixel being read.
- `pix_data` in 24: colour, valid on the cycle after `pix_rd`.
- `brightness` in 3: right-shift applied per colour byte; exists only with `LED_SEQ_BRIGHTNESS_EN`.
- `led_data` out 24: colour to the serializer.
- `led_valid` out 1: data-valid to the serializer.
- `led_latch` out 1: marks the current pixel as the last of the frame.
- `led_ready` in 1: serializer ready; falls once it has taken the data.
- `busy` out 1: a frame is in progress.
- `frame_done` out 1: one-cycle pulse after the last pixel is accepted.
- `frame_skip` out 1: one-cycle pulse when a tick or force arrives while busy.

## Operation
- Refresh timer: a free-running REFRESH_LOG2-bit counter. `tick` is registered high for one cycle when the counter is all ones.
- Start condition: `start = (tick | force_refresh) & enable`.
- States and transitions:
  - IDLE: idx←0, all strobes low. On `start`, go to FETCH.
  - FETCH: `pix_rd`=1, `pix_addr`=idx for exactly one cycle. Go to CAPTURE.
  - CAPTURE: `led_data`←scale(`pix_data`); `led_latch`←(idx==NUM_LEDS-1). Go to WAIT_READY.
  - WAIT_READY: when `led_ready`=1, `led_valid`←1. Go to WAIT_ACCEPT.
  - WAIT_ACCEPT: when `led_ready`=0, `led_valid`←0 and idx←idx+1. If the old idx was NUM_LEDS-1, pulse `frame_done` and go to IDLE; otherwise go to FETCH.
- `led_data` and `led_latch` are stable from CAPTURE until the next CAPTURE. `led_valid` never rises while `led_ready`=0.
- `busy` = (state != IDLE).
- `frame_skip`: a `tick` or `force_refresh` while busy is dropped, never queued, and `frame_skip` pulses. A `tick` while `enable`=0 in IDLE is dropped silently.
- Simultaneous `tick` and `force_refresh`: this starts one frame only.
- `enable` deasserted mid-frame: the frame runs to completion.
- Reset mid-frame: the FSM returns to IDLE. idx, the timer and every output go to 0, including `led_valid`, `led_latch` and `led_data`. The serializer shares the same reset.

## Timing
- Start latency: `start` sampled in IDLE at cycle N gives `pix_rd` at N+1 and `led_data` updated at N+3.
- Minimum per-pixel overhead: 4 cycles plus the serializer's ready-low time.
- idx is ADDR_W bits and never wraps past NUM_LEDS-1.
- `frame_done` occurs one cycle after the final `led_ready` fall is sampled.

## Configuration
- `LED_SEQ_BRIGHTNESS_EN` defined: the `brightness` port exists. Each byte of `pix_data` is logically shifted right by `brightness` in CAPTURE. The value is sampled in IDLE on `start` and held for the whole frame.
- `LED_SEQ_BRIGHTNESS_EN` undefined: the port is absent and `led_data` = `pix_data` unchanged.

## Structure
- Package `led_seq_pkg` holds:
  - the state encoding (IDLE, FETCH, CAPTURE, WAIT_READY, WAIT_ACCEPT);
  - `PIX_W`=24;
  - the default NUM_LEDS and REFRESH_LOG2.
- Sub-module `refresh_timer` (clk20, reset, tick) holds the counter and the registered tick. The FSM stays in the top module.

## Test plan
- NUM_LEDS=4, REFRESH_LOG2=6, serializer model with ready low for 10 cycles after valid:
  - Pixel source returns 0x010203·idx.
  - Required: exactly 4 `pix_rd` strobes (addr 0..3) and 4 `led_valid` pulses.
  - `led_latch`=1 only with 0x030609, followed by one `frame_done`.
- `force_refresh` in IDLE at cycle N -> `pix_rd` at N+1, `busy` from N+1.
- `tick` mid-frame -> one `frame_skip` pulse; no second frame starts until the next tick after `frame_done`.
- `enable`=0 with 3 ticks -> no `pix_rd`. `enable` dropped mid-frame -> the remaining pixels still go out.
- `reset` asserted in WAIT_ACCEPT -> next cycle all outputs 0 and state IDLE; the next tick restarts at addr 0.
- With `LED_SEQ_BRIGHTNESS_EN` and `brightness`=2, `pix_data`=0xFF8004 -> `led_data`=0x3F2001. Without the macro -> `led_data`=0xFF8004.
